// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, controller state and operand bundle type
package regfile_pkg;
    localparam int XLEN = 32;
    localparam int AW = 4;
    localparam int NREG = 16;
    typedef enum logic [0:0] {INIT = 1'b0, RUN = 1'b1} state_e;
    typedef struct packed {
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [AW-1:0]   rd;
        logic            rd_en;
    } op_bundle_t;
endpackage

// File: rtl/regfile_access_ctrl_if.sv
// regfile_access_ctrl_if: decode, execute, writeback and regfile-port signals of the access controller
interface regfile_access_ctrl_if;
    import regfile_pkg::*;
    logic            init_done;
    logic            issue_valid;
    logic            issue_ready;
    logic [AW-1:0]   issue_rs1;
    logic [AW-1:0]   issue_rs2;
    logic [AW-1:0]   issue_rd;
    logic            issue_rd_en;
    logic            op_valid;
    logic            op_ready;
    logic [XLEN-1:0] op_rs1_val;
    logic [XLEN-1:0] op_rs2_val;
    logic [AW-1:0]   op_rd;
    logic            op_rd_en;
    logic            wb_valid;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            rs1_read;
    logic [AW-1:0]   rs1_addr;
    logic [XLEN-1:0] rs1_rdata;
    logic            rs2_read;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs2_rdata;
    logic            rd_write;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_wdata;
    modport slave (
        output init_done, issue_ready, op_valid, op_rs1_val, op_rs2_val, op_rd, op_rd_en,
               rs1_read, rs1_addr, rs2_read, rs2_addr, rd_write, rd_addr, rd_wdata,
        input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_en, op_ready,
               wb_valid, wb_addr, wb_data, rs1_rdata, rs2_rdata
    );
    modport master (
        input  init_done, issue_ready, op_valid, op_rs1_val, op_rs2_val, op_rd, op_rd_en,
               rs1_read, rs1_addr, rs2_read, rs2_addr, rd_write, rd_addr, rd_wdata,
        output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_en, op_ready,
               wb_valid, wb_addr, wb_data, rs1_rdata, rs2_rdata
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: busy bits for pending writebacks and the issue hazard lookup
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_set,
    input  logic [AW-1:0] i_set_addr,
    input  logic          i_clr,
    input  logic [AW-1:0] i_clr_addr,
    input  logic [AW-1:0] i_rs1,
    input  logic [AW-1:0] i_rs2,
    input  logic [AW-1:0] i_rd,
    input  logic          i_rd_en,
    output logic          o_hazard
);
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_clr_mask;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_busy_eff;

    assign w_clr_mask = i_clr ? (NREG'(1) << i_clr_addr) : '0;
    assign w_set_mask = (i_set && i_set_addr != '0) ? (NREG'(1) << i_set_addr) : '0;
    // a writeback landing this cycle already resolves its dependency
    assign w_busy_eff = r_busy & ~w_clr_mask;
    assign o_hazard = w_busy_eff[i_rs1] | w_busy_eff[i_rs2] | (i_rd_en & w_busy_eff[i_rd]);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_busy <= '0;
        else r_busy <= w_busy_eff | w_set_mask;
endmodule

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: zero-fills the register file, then issues operand reads with
// busy-bit stalls and same-cycle writeback forwarding, and commits writebacks.
module regfile_access_ctrl
    import regfile_pkg::*;
(
    input logic clk,
    input logic rst_n,
    regfile_access_ctrl_if.slave bus
);
    state_e          r_state;
    logic [AW-1:0]   r_cnt;
    logic            r_valid;
    logic            r_fresh;
    logic            r_fwd1;
    logic            r_fwd2;
    logic [XLEN-1:0] r_fwd_val1;
    logic [XLEN-1:0] r_fwd_val2;
    op_bundle_t      r_op;
    op_bundle_t      w_op;
    logic            w_run;
    logic            w_wb;
    logic            w_hazard;
    logic            w_accept;

    assign w_run = r_state == RUN;
    assign w_wb = w_run & bus.wb_valid;
    assign w_accept = bus.issue_valid & bus.issue_ready;

    regfile_scoreboard u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_set     (w_accept & bus.issue_rd_en),
        .i_set_addr(bus.issue_rd),
        .i_clr     (w_wb),
        .i_clr_addr(bus.wb_addr),
        .i_rs1     (bus.issue_rs1),
        .i_rs2     (bus.issue_rs2),
        .i_rd      (bus.issue_rd),
        .i_rd_en   (bus.issue_rd_en),
        .o_hazard  (w_hazard)
    );

    assign bus.init_done = w_run;
    assign bus.issue_ready = w_run & ~w_hazard & (~r_valid | bus.op_ready);
    assign bus.rs1_read = w_accept;
    assign bus.rs2_read = w_accept;
    assign bus.rs1_addr = bus.issue_rs1;
    assign bus.rs2_addr = bus.issue_rs2;
    // zero-fill owns the write port until RUN; reset gates it off at once
    assign bus.rd_write = w_run ? (w_wb && bus.wb_addr != '0) : rst_n;
    assign bus.rd_addr = w_run ? bus.wb_addr : r_cnt;
    assign bus.rd_wdata = w_run ? bus.wb_data : '0;

    // read data is only valid in the first bundle cycle; later cycles replay the held copy
    always_comb begin
        w_op = r_op;
        w_op.rs1_val = !r_fresh ? r_op.rs1_val : r_fwd1 ? r_fwd_val1 : bus.rs1_rdata;
        w_op.rs2_val = !r_fresh ? r_op.rs2_val : r_fwd2 ? r_fwd_val2 : bus.rs2_rdata;
    end

    assign bus.op_valid = r_valid;
    assign bus.op_rs1_val = w_op.rs1_val;
    assign bus.op_rs2_val = w_op.rs2_val;
    assign bus.op_rd = w_op.rd;
    assign bus.op_rd_en = w_op.rd_en;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= INIT;
            r_cnt <= '0;
            r_valid <= 1'b0;
            r_fresh <= 1'b0;
            r_fwd1 <= 1'b0;
            r_fwd2 <= 1'b0;
            r_fwd_val1 <= '0;
            r_fwd_val2 <= '0;
            r_op <= '0;
        end else begin
            if (!w_run) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == AW'(NREG - 1)) r_state <= RUN;
            end
            r_fresh <= w_accept;
            if (w_accept) begin
                r_valid <= 1'b1;
                r_fwd1 <= bus.issue_rs1 == '0 || (w_wb && bus.wb_addr == bus.issue_rs1);
                r_fwd2 <= bus.issue_rs2 == '0 || (w_wb && bus.wb_addr == bus.issue_rs2);
                r_fwd_val1 <= bus.issue_rs1 == '0 ? '0 : bus.wb_data;
                r_fwd_val2 <= bus.issue_rs2 == '0 ? '0 : bus.wb_data;
                r_op.rd <= bus.issue_rd;
                r_op.rd_en <= bus.issue_rd_en;
            end else begin
                if (bus.op_ready) r_valid <= 1'b0;
                r_op <= w_op;
            end
        end
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl: random and directed traffic against an architectural register/busy model,
// with a bundle scoreboard and a write-port scoreboard.
module tb_regfile_access_ctrl;
    import regfile_pkg::*;

    typedef struct {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [AW-1:0]   rd;
        logic            rd_en;
    } exp_op_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_access_ctrl_if bus();
    regfile_access_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [XLEN-1:0] mem [NREG];
    logic [XLEN-1:0] arch [NREG];
    bit busy_m [NREG];
    int outstanding = 0;
    int init_cyc = 0;
    exp_op_t op_q[$];
    logic [AW+XLEN-1:0] wr_q[$];
    int vectors = 0;
    int errors = 0;
    exp_op_t held;
    bit have_held = 0;

    // register file with one-cycle read latency and read-before-write
    always @(posedge clk) begin
        if (bus.rs1_read) bus.rs1_rdata <= mem[bus.rs1_addr];
        if (bus.rs2_read) bus.rs2_rdata <= mem[bus.rs2_addr];
        if (bus.rd_write) mem[bus.rd_addr] <= bus.rd_wdata;
    end

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit hz(input logic [AW-1:0] a);
        return busy_m[a] && !(bus.wb_valid && bus.wb_addr == a);
    endfunction

    always @(negedge clk) if (bus.rd_write) begin
        if (wr_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_write: addr %0d data %h, none expected", bus.rd_addr, bus.rd_wdata);
        end else begin
            logic [AW+XLEN-1:0] e;
            e = wr_q.pop_front();
            check("rd_addr", XLEN'(bus.rd_addr), XLEN'(e[AW+XLEN-1:XLEN]));
            check("rd_wdata", bus.rd_wdata, e[XLEN-1:0]);
        end
    end

    always @(negedge clk) begin
        if (bus.op_valid && have_held) begin
            check("hold_rs1", bus.op_rs1_val, held.a);
            check("hold_rs2", bus.op_rs2_val, held.b);
            check("hold_rd", XLEN'({bus.op_rd, bus.op_rd_en}), XLEN'({held.rd, held.rd_en}));
        end
        have_held = bus.op_valid && !bus.op_ready;
        held = '{bus.op_rs1_val, bus.op_rs2_val, bus.op_rd, bus.op_rd_en};
        if (bus.op_valid && bus.op_ready) begin
            if (op_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_bundle: rs1 %h rs2 %h, none expected", bus.op_rs1_val, bus.op_rs2_val);
            end else begin
                exp_op_t e;
                e = op_q.pop_front();
                check("op_rs1_val", bus.op_rs1_val, e.a);
                check("op_rs2_val", bus.op_rs2_val, e.b);
                check("op_rd", XLEN'(bus.op_rd), XLEN'(e.rd));
                check("op_rd_en", XLEN'(bus.op_rd_en), XLEN'(e.rd_en));
            end
        end
    end

    // one clock of the reference model; inputs must be set before calling
    task automatic step();
        bit run, rdy, acc;
        @(negedge clk);
        run = init_cyc >= NREG;
        rdy = run && !(hz(bus.issue_rs1) || hz(bus.issue_rs2) || (bus.issue_rd_en && hz(bus.issue_rd)))
              && (outstanding == 0 || bus.op_ready);
        acc = rdy && bus.issue_valid;
        check("init_done", XLEN'(bus.init_done), XLEN'(run));
        check("op_valid", XLEN'(bus.op_valid), XLEN'(outstanding > 0));
        check("issue_ready", XLEN'(bus.issue_ready), XLEN'(rdy));
        check("rs_read", XLEN'({bus.rs1_read, bus.rs2_read}), XLEN'({acc, acc}));
        if (acc) check("rs_addr", XLEN'({bus.rs1_addr, bus.rs2_addr}), XLEN'({bus.issue_rs1, bus.issue_rs2}));
        if (!run) init_cyc++;
        if (run && bus.wb_valid) begin
            if (bus.wb_addr != '0) arch[bus.wb_addr] = bus.wb_data;
            busy_m[bus.wb_addr] = 0;
        end
        if (outstanding > 0 && bus.op_ready) outstanding--;
        if (acc) begin
            op_q.push_back('{arch[bus.issue_rs1], arch[bus.issue_rs2], bus.issue_rd, bus.issue_rd_en});
            outstanding++;
            if (bus.issue_rd_en && bus.issue_rd != '0) busy_m[bus.issue_rd] = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit ready = 1);
        bus.issue_valid = 0;
        bus.wb_valid = 0;
        bus.op_ready = ready;
    endtask

    task automatic issue(input int rs1, input int rs2, input int rd, input bit rd_en);
        bus.issue_valid = 1;
        bus.issue_rs1 = AW'(rs1);
        bus.issue_rs2 = AW'(rs2);
        bus.issue_rd = AW'(rd);
        bus.issue_rd_en = rd_en;
    endtask

    task automatic drive_wb(input int a, input logic [XLEN-1:0] d);
        bus.wb_valid = 1;
        bus.wb_addr = AW'(a);
        bus.wb_data = d;
        if (a != 0) wr_q.push_back({AW'(a), d});
    endtask

    task automatic rand_inputs();
        int a;
        idle($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) != 0)
            issue($urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1),
                  1'($urandom_range(0, 1)));
        if ($urandom_range(0, 2) == 0) begin
            a = $urandom_range(0, NREG - 1);
            if ($urandom_range(0, 3) != 0)
                for (int k = 0; k < NREG; k++) if (busy_m[(a + k) % NREG]) begin
                    a = (a + k) % NREG;
                    break;
                end
            drive_wb(a, $urandom);
        end
    endtask

    // called just after a rising edge; checks the immediate reset values, then releases
    task automatic do_reset();
        idle(0);
        rst_n = 0;
        #1;
        check("rst_init_done", XLEN'(bus.init_done), '0);
        check("rst_op_valid", XLEN'(bus.op_valid), '0);
        check("rst_issue_ready", XLEN'(bus.issue_ready), '0);
        check("rst_rd_write", XLEN'(bus.rd_write), '0);
        check("rst_reads", XLEN'({bus.rs1_read, bus.rs2_read}), '0);
        @(posedge clk);
        #1;
        rst_n = 1;
        init_cyc = 0;
        outstanding = 0;
        op_q.delete();
        wr_q.delete();
        for (int r = 0; r < NREG; r++) begin
            arch[r] = '0;
            busy_m[r] = 0;
            wr_q.push_back({AW'(r), XLEN'(0)});
        end
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) mem[r] = $urandom;
        bus.issue_rs1 = '0;
        bus.issue_rs2 = '0;
        bus.issue_rd = '0;
        bus.issue_rd_en = 0;
        bus.wb_addr = '0;
        bus.wb_data = '0;
        idle(0);
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        idle();
        repeat (NREG + 1) step();
        check("zero_fill_count", XLEN'(wr_q.size()), '0);
        issue(5, 9, 0, 0);
        step();
        idle();
        step();
        drive_wb(3, 32'hDEADBEEF);
        step();
        idle();
        issue(3, 0, 0, 0);
        step();
        idle();
        step();
        issue(1, 2, 7, 1);
        step();
        issue(7, 0, 0, 0);
        repeat (3) step();
        drive_wb(7, 32'h12345678);
        step();
        idle();
        step();
        bus.op_ready = 0;
        issue(5, 6, 8, 0);
        repeat (4) step();
        bus.op_ready = 1;
        repeat (4) step();
        idle();
        drive_wb(0, 32'hFFFFFFFF);
        step();
        idle();
        issue(0, 0, 0, 0);
        step();
        idle();
        step();
        repeat (3000) begin
            rand_inputs();
            step();
        end
        for (int r = 1; r < NREG; r++) if (busy_m[r]) begin
            idle();
            drive_wb(r, $urandom);
            step();
        end
        idle();
        repeat (2) step();
        idle(0);
        issue(1, 2, 4, 1);
        step();
        idle(0);
        step();
        do_reset();
        idle();
        repeat (NREG) step();
        check("refill_count", XLEN'(wr_q.size()), '0);
        issue(4, 4, 4, 1);
        step();
        idle();
        repeat (2) step();
        check("bundles_drained", XLEN'(op_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Client-side controller that drives the 2-read/1-write register file ports: accepts decoded instructions, issues rs1/rs2 reads, returns operands, and commits writebacks.
- Holds a 16-entry busy scoreboard so late writebacks (loads, multi-cycle ops) stall dependent instructions.
- Forwards same-cycle writeback data onto reads.
- After reset, zero-fills all registers, since the storage lanes themselves have no reset.
- Sits between decode and execute in the RV32E core.

Parameters:
- XLEN, 32, data width.
- AW, 4, register address width.
- NREG, 16, number of architectural registers; must equal 2**AW.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- init_done  out  1  high once zero-fill is complete
- issue_valid  in  1  decode offers an instruction
- issue_ready  out  1  controller accepts the instruction this cycle
- issue_rs1  in  AW  source 1 address
- issue_rs2  in  AW  source 2 address
- issue_rd  in  AW  destination address
- issue_rd_en  in  1  instruction will write rd later
- op_valid  out  1  operand bundle valid
- op_ready  in  1  execute consumes the bundle
- op_rs1_val  out  XLEN  source 1 value
- op_rs2_val  out  XLEN  source 2 value
- op_rd  out  AW  destination, carried through
- op_rd_en  out  1  destination enable, carried through
- wb_valid  in  1  writeback strobe
- wb_addr  in  AW  writeback register
- wb_data  in  XLEN  writeback data
- rs1_read  out  1  regfile read port 1 enable
- rs1_addr  out  AW  regfile read port 1 address
- rs1_rdata  in  XLEN  regfile read data 1, valid one cycle after the read
- rs2_read  out  1  regfile read port 2 enable
- rs2_addr  out  AW  regfile read port 2 address
- rs2_rdata  in  XLEN  regfile read data 2
- rd_write  out  1  regfile write enable
- rd_addr  out  AW  regfile write address
- rd_wdata  out  XLEN  regfile write data

Behaviour:

Reset:
- Asserting rst_n low immediately forces: init_done=0, op_valid=0, issue_ready=0, rd_write=0, rs1_read=0, rs2_read=0, all busy bits 0, init counter 0, state INIT.
- Reset mid-operation discards any in-flight bundle; zero-fill restarts from address 0.

State machine:
- INIT: each cycle writes rd_write=1, rd_addr=cnt, rd_wdata=0, then cnt++. After cnt=NREG-1 is written, go to RUN and set init_done=1 on the next cycle. Zero-fill takes 16 cycles.
- INIT input handling: issue_ready=0, and wb_valid is ignored (protocol error, dropped).
- RUN: no exit except reset.

Register 0:
- Always reads 0.
- Writebacks to address 0 are dropped (rd_write stays 0).
- Register 0 is never marked busy.

Hazard and issue:
- hazard = busy'[rs1] | busy'[rs2] | (issue_rd_en & busy'[issue_rd]), where busy' = busy with the current cycle's writeback bit cleared.
- issue_ready = RUN & ~hazard & (~op_valid | op_ready).
- Accept = issue_valid & issue_ready.

Read timing:
- On accept in cycle N: rs1_read=rs2_read=1 with the issue addresses.
- The bundle is registered at the N+1 edge: op_valid=1 in N+1, values taken from rs*_rdata.
- Latency from accept to op_valid is 1 cycle.

Forwarding:
- A writeback in cycle N to a register read in cycle N supplies wb_data to that operand, overriding rs*_rdata.

Operand hold:
- op_valid & ~op_ready holds every op_* output stable and blocks issue.
- Back-to-back issue runs at full rate while op_ready=1.

Scoreboard:
- An accept with issue_rd_en=1 and issue_rd!=0 sets busy[issue_rd].
- wb_valid clears busy[wb_addr].
- A writeback to a non-busy register is legal and is committed.
- If the same bit is cleared and set in one cycle, set wins.

Writeback path:
- In RUN, rd_write=wb_valid & (wb_addr!=0), with rd_addr=wb_addr and rd_wdata=wb_data, combinationally.

Decomposition:
- Package regfile_pkg holds XLEN, AW, NREG, the state enum {INIT, RUN}, and the operand bundle struct {rs1_val, rs2_val, rd, rd_en}.
- One sub-module, regfile_scoreboard, holds the busy vector, set/clear logic and the three-way hazard lookup.

Test Plan:
- Reset then idle: rd_write is high for exactly 16 cycles with rd_addr 0..15 and rd_wdata 0, then init_done=1. Reads of x5/x9 then return 0.
- wb x3=0xDEADBEEF, then issue rs1=3 rs2=0 the next cycle -> op_valid 1 cycle after accept, op_rs1_val=0xDEADBEEF, op_rs2_val=0.
- Issue rd=7 rd_en=1, then issue rs1=7 -> issue_ready=0 until wb x7=0x12345678. Accept happens in the wb cycle with the forwarded value, so op_rs1_val=0x12345678.
- Hold op_ready=0 for 3 cycles with issue_valid=1 -> op_* outputs stable, issue_ready=0, no rs*_read pulses. Releasing op_ready resumes one bundle per cycle.
- wb to x0 with data 0xFFFFFFFF -> rd_write stays 0, and a later read of x0 returns 0.
- Assert rst_n mid-stream with x4 busy and op_valid=1 -> outputs clear immediately, busy is empty, and zero-fill restarts from addr 0.
